// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : npu_pkg
//  Brief   : Shared defaults, state encoding and length clamp for the NPU
//            mac datapath and its operand loader.
//  Rev     : 1.0  initial release
// ============================================================================
package npu_pkg;

  localparam int DEF_MAX_MACS   = 64;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // A zero-length request still runs one lane; anything beyond the lane
  // count is truncated to the full vector.
  function automatic int unsigned clamp_len(input int unsigned n,
                                            input int unsigned max_len);
    if (n == 0)            return 1;
    else if (n > max_len)  return max_len;
    else                   return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane_packer.sv
`default_nettype none
// ============================================================================
//  Module  : mac_lane_packer
//  Brief   : Lane register file for the operand loader. Per-lane write enable,
//            a clear that loads lane 0 and zeroes every other lane, and flat
//            packed outputs.
//  Rev     : 1.0  initial release
// ============================================================================
module mac_lane_packer #(
  parameter int MAX_MACS   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           wr_en_i,
  input  logic [CNT_WIDTH-1:0]           lane_idx_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [DATA_WIDTH-1:0]          weight_i,
  output logic [MAX_MACS*DATA_WIDTH-1:0] data_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] weight_o
);

  genvar i;
  generate
    for (i = 0; i < MAX_MACS; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] data_q;
      logic [DATA_WIDTH-1:0] weight_q;

      // Lane storage: a clear starts a new vector so no lane from a previous
      // longer vector can leak into this one.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q   <= '0;
          weight_q <= '0;
        end else if (clear_i) begin
          if (i == 0) begin
            data_q   <= data_i;
            weight_q <= weight_i;
          end else begin
            data_q   <= '0;
            weight_q <= '0;
          end
        end else if (wr_en_i && (lane_idx_i == CNT_WIDTH'(i))) begin
          data_q   <= data_i;
          weight_q <= weight_i;
        end
      end

      assign data_o[i*DATA_WIDTH +: DATA_WIDTH]   = data_q;
      assign weight_o[i*DATA_WIDTH +: DATA_WIDTH] = weight_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mac_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module  : mac_operand_loader
//  Brief   : Packs a serial (data, weight) stream into MAX_MACS-lane operand
//            vectors, issues them to the mac, holds until valid_out, and
//            presents the captured dot product on a valid/ready result port.
//  Rev     : 1.0  initial release
// ============================================================================
module mac_operand_loader
  import npu_pkg::*;
#(
  parameter int MAX_MACS   = DEF_MAX_MACS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CNT_WIDTH-1:0]           cfg_num_macs,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [DATA_WIDTH-1:0]          in_weight,
  output logic [CNT_WIDTH-1:0]           mac_num_macs_o,
  output logic                           mac_valid_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] mac_data_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] mac_weight_o,
  input  logic                           mac_valid_out_i,
  input  logic [2*DATA_WIDTH-1:0]        mac_out_i,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [2*DATA_WIDTH-1:0]        res_data,
  output logic                           busy
);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [CNT_WIDTH-1:0]    len_q, len_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;

  logic                    w_accept;
  logic                    w_clear;
  logic                    w_wr_en;
  logic [CNT_WIDTH-1:0]    w_len_cfg;
  logic [CNT_WIDTH-1:0]    w_count_inc;

  assign w_len_cfg   = CNT_WIDTH'(clamp_len(32'(cfg_num_macs), MAX_MACS));
  assign w_count_inc = count_q + CNT_WIDTH'(1);

  // Element acceptance and mac issue are decoded from distinct states, so
  // they can never be high together.
  assign in_ready       = (state_q == IDLE) || (state_q == LOAD);
  assign w_accept       = in_valid && in_ready;
  assign mac_valid_o    = (state_q == WAIT);
  assign res_valid      = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign mac_num_macs_o = len_q;
  assign res_data       = res_q;

  // State, element count, latched length and captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      res_q   <= res_d;
    end
  end

  // Next-state decode and lane write control.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    res_d   = res_q;
    w_clear = 1'b0;
    w_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          len_d   = w_len_cfg;
          count_d = CNT_WIDTH'(1);
          w_clear = 1'b1;
          state_d = (w_len_cfg == CNT_WIDTH'(1)) ? WAIT : LOAD;
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          count_d = w_count_inc;
          if (w_count_inc == len_q) state_d = WAIT;
        end
      end
      WAIT: begin
        if (mac_valid_out_i) begin
          res_d   = mac_out_i;
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mac_lane_packer #(
    .MAX_MACS   (MAX_MACS),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (w_clear),
    .wr_en_i    (w_wr_en),
    .lane_idx_i (count_q),
    .data_i     (in_data),
    .weight_i   (in_weight),
    .data_o     (mac_data_o),
    .weight_o   (mac_weight_o)
  );

endmodule
`default_nettype wire
